uart_tx_arb: RTL and testbench

Shares one UART transmit line among NREQ byte-wide requesters, e.g. per-hart console ports in the smart_run testbench/SoC. Grants are round-robin; each granted byte is serialized as 8N1 (optionally 8E1) on `sout` at BAUD. Frame timing uses the same 16x-oversampled baud tick scheme as the UART monitor, so that monitor decodes `sout` directly.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_tx_arb_if.sv | 21 ++
 rtl/uart_tx_ser.sv | 170 +++++++++++++++++
 rtl/uart_tx_arb.sv | 91 +++++++++
 tb/tb_uart_tx_arb.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversample and data-width
// constants, baud divider formula and the even-parity helper, so that the
// transmitter and the UART monitor agree on frame timing.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int TICK_W     = 4;   // counts OVERSAMPLE ticks per bit
  localparam int BIT_W      = 3;   // counts DATA_BITS data bits

  // Baud-tick reload value: the divider counts this value down to zero.
  function automatic int calc_div(input int fcpu, input int baud);
    return fcpu / (baud * OVERSAMPLE) - 1;
  endfunction

  // Even parity bit: XOR of all data bits.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester-side handshake bundle of uart_tx_arb: per-requester valid,
// packed data bytes and the one-hot accept pulse.
interface uart_tx_arb_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_vld;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_rdy;

  modport master (
    output req_vld,
    output req_data,
    input  req_rdy
  );

  modport slave (
    input  req_vld,
    input  req_data,
    output req_rdy
  );
endinterface

// File: rtl/uart_tx_ser.sv
// Single-byte UART serializer: 16x baud divider, tick and bit counters,
// shift register and line FSM. A load pulse in IDLE starts one frame.
// Optional feature: UART_TX_PARITY_EN adds an even parity bit (8E1),
// otherwise frames are 8N1.
module uart_tx_ser
  import uart_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data,
  output logic                 sout,
  output logic                 busy
);

  localparam int DW = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam logic [DW-1:0] DIV_RELOAD = DW'(DIV);

  uart_state_e            state_r,    state_nxt_s;
  logic [DW-1:0]          div_r,      div_nxt_s;
  logic [TICK_W-1:0]      tick_cnt_r, tick_cnt_nxt_s;
  logic [BIT_W-1:0]       bit_cnt_r,  bit_cnt_nxt_s;
  logic [DATA_BITS-1:0]   shreg_r,    shreg_nxt_s;
  logic                   sout_r,     sout_nxt_s;
  logic                   busy_r,     busy_nxt_s;
  logic                   tick_s;
  logic                   bit_end_s;
`ifdef UART_TX_PARITY_EN
  logic                   par_r,      par_nxt_s;
`endif

  // Next-state logic: divider, tick/bit counting, shifting and line level
  always_comb begin
    state_nxt_s    = state_r;
    div_nxt_s      = div_r;
    tick_cnt_nxt_s = tick_cnt_r;
    bit_cnt_nxt_s  = bit_cnt_r;
    shreg_nxt_s    = shreg_r;
    sout_nxt_s     = 1'b1;
    busy_nxt_s     = 1'b0;
    tick_s         = 1'b0;
    bit_end_s      = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nxt_s      = par_r;
`endif

    // Divider only runs while a frame is on the line.
    if (state_r != ST_IDLE) begin
      tick_s = (div_r == '0);
      if (tick_s) begin
        div_nxt_s      = DIV_RELOAD;
        tick_cnt_nxt_s = tick_cnt_r + TICK_W'(1);
      end else begin
        div_nxt_s      = div_r - DW'(1);
      end
    end else begin
      tick_s = 1'b0;
    end
    // A bit period ends on the 16th tick.
    bit_end_s = tick_s && (tick_cnt_r == {TICK_W{1'b1}});

    case (state_r)
      ST_IDLE: begin
        if (load) begin
          state_nxt_s    = ST_START;
          div_nxt_s      = DIV_RELOAD;
          tick_cnt_nxt_s = '0;
          bit_cnt_nxt_s  = '0;
          shreg_nxt_s    = data;
`ifdef UART_TX_PARITY_EN
          par_nxt_s      = even_parity(data);
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          shreg_nxt_s   = shreg_r >> 1;
          bit_cnt_nxt_s = bit_cnt_r + BIT_W'(1);
          if (bit_cnt_r == {BIT_W{1'b1}}) begin
`ifdef UART_TX_PARITY_EN
            state_nxt_s = ST_PAR;
`else
            state_nxt_s = ST_STOP;
`endif
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_PAR: begin
`ifdef UART_TX_PARITY_EN
        if (bit_end_s) begin
          state_nxt_s = ST_STOP;
        end else begin
          state_nxt_s = ST_PAR;
        end
`else
        // Unreachable without parity; recover to a clean idle line.
        state_nxt_s = ST_IDLE;
`endif
      end
      ST_STOP: begin
        if (bit_end_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // Line level follows the state being entered, so sout is registered.
    case (state_nxt_s)
      ST_START: sout_nxt_s = 1'b0;
      ST_DATA:  sout_nxt_s = shreg_nxt_s[0];
`ifdef UART_TX_PARITY_EN
      ST_PAR:   sout_nxt_s = par_nxt_s;
`endif
      default:  sout_nxt_s = 1'b1;
    endcase

    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // Frame state registers; reset forces an idle-high line and drops any byte
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r    <= ST_IDLE;
      div_r      <= '0;
      tick_cnt_r <= '0;
      bit_cnt_r  <= '0;
      shreg_r    <= '0;
      sout_r     <= 1'b1;
      busy_r     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_r      <= 1'b0;
`endif
    end else begin
      state_r    <= state_nxt_s;
      div_r      <= div_nxt_s;
      tick_cnt_r <= tick_cnt_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      shreg_r    <= shreg_nxt_s;
      sout_r     <= sout_nxt_s;
      busy_r     <= busy_nxt_s;
`ifdef UART_TX_PARITY_EN
      par_r      <= par_nxt_s;
`endif
    end
  end

  assign sout = sout_r;
  assign busy = busy_r;

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmit line among NREQ byte-wide
// requesters. Keeps the grant pointer and the accept handshake; the frame
// itself is produced by uart_tx_ser.
// Optional feature: UART_TX_PARITY_EN (8E1 frames, handled in uart_tx_ser).
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int FCPU = 100000000,
  parameter int BAUD = 19200
) (
  input  logic                    clk,
  input  logic                    rst_b,
  uart_tx_arb_if.slave            req_if,
  output logic                    sout,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int GW  = $clog2(NREQ);
  localparam int DIV = calc_div(FCPU, BAUD);

  logic [GW-1:0]        grant_id_r;
  logic                 run_r;
  logic [GW-1:0]        cand_s;
  logic [GW-1:0]        pick_s;
  logic                 found_s;
  logic                 grant_s;
  logic [NREQ-1:0]      rdy_s;
  logic [DATA_BITS-1:0] load_data_s;
  logic                 ser_busy_s;

  // Round-robin pick: first valid requester after the last granted one
  always_comb begin
    found_s     = 1'b0;
    pick_s      = '0;
    cand_s      = '0;
    grant_s     = 1'b0;
    rdy_s       = '0;
    load_data_s = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = GW'((int'(grant_id_r) + k) % NREQ);
      if (!found_s && req_if.req_vld[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
    // Accept only from an idle line; run_r keeps rdy low through reset.
    grant_s = run_r && !ser_busy_s && found_s;
    if (grant_s) begin
      rdy_s[pick_s] = 1'b1;
      load_data_s   = req_if.req_data[int'(pick_s)*DATA_BITS +: DATA_BITS];
    end else begin
      rdy_s       = '0;
      load_data_s = '0;
    end
  end

  // Grant pointer advances only when a byte is accepted
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      grant_id_r <= GW'(NREQ - 1);
      run_r      <= 1'b0;
    end else begin
      run_r <= 1'b1;
      if (grant_s) begin
        grant_id_r <= pick_s;
      end else begin
        grant_id_r <= grant_id_r;
      end
    end
  end

  assign req_if.req_rdy = rdy_s;
  assign grant_id       = grant_id_r;
  assign busy           = ser_busy_s;

  uart_tx_ser #(
    .DIV (DIV)
  ) u_ser (
    .clk   (clk),
    .rst_b (rst_b),
    .load  (grant_s),
    .data  (load_data_s),
    .sout  (sout),
    .busy  (ser_busy_s)
  );

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb (FCPU=3200, BAUD=100 -> 32-cycle bit).
// Reference: frame bit list derived from the byte and round-robin pick over
// the requester list; random bytes/masks via $urandom.
module tb_uart_tx_arb;

  localparam int NREQ = 4;
  localparam int FCPU = 3200;
  localparam int BAUD = 100;
  localparam int BITP = 32;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * BITP;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       sout;
  logic       busy;
  logic [1:0] grant_id;

  uart_tx_arb_if #(.NREQ(NREQ)) rif ();

  uart_tx_arb #(.NREQ(NREQ), .FCPU(FCPU), .BAUD(BAUD)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .req_if   (rif),
    .sout     (sout),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ptr_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Serve order: requesters after the pointer, wrapping; first valid wins.
  function automatic int model_pick(input int ptr, input logic [NREQ-1:0] vld);
    int order[$];
    for (int k = 1; k <= NREQ; k++) order.push_back((ptr + k) % NREQ);
    foreach (order[i]) if (vld[order[i]]) return order[i];
    return -1;
  endfunction

  // Expected line level of bit slot j of a frame carrying byte d.
  function automatic logic frame_bit(input logic [7:0] d, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
    if (NBITS == 11 && j == 9) return ($countones(d) % 2) == 1;
    return 1'b1;
  endfunction

  task automatic set_req(input int i, input logic [7:0] d);
    rif.req_vld[i] = 1'b1;
    rif.req_data[8*i +: 8] = d;
  endtask

  task automatic wait_grant(output int idx, output int gcyc);
    idx = -1;
    gcyc = 0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (|rif.req_rdy) begin
        for (int i = 0; i < NREQ; i++) if (rif.req_rdy[i]) idx = i;
        gcyc = cyc;
        check("rdy_onehot", $countones(rif.req_rdy), 1);
        break;
      end
    end
    if (idx < 0) check("grant_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    ptr_m = NREQ - 1;
  endtask

  // Wait for one grant, check pick and the whole frame on sout.
  task automatic serve(input bit drop, input int abort_at,
                       input logic [NREQ-1:0] raise_mask, input int raise_at,
                       output int idx, output int gcyc);
    int          exp_idx;
    logic [7:0]  exp_d;
    logic [10:0] mid;
    int          bit_err, busy_err, rdy_err;
    wait_grant(idx, gcyc);
    if (idx < 0) return;
    exp_idx = model_pick(ptr_m, rif.req_vld);
    check("grant_idx", idx, exp_idx);
    check("busy_at_grant", busy, 0);
    ptr_m = idx;
    exp_d = rif.req_data[8*idx +: 8];
    @(posedge clk);
    #1;
    check("grant_id", grant_id, idx);
    if (drop) rif.req_vld[idx] = 1'b0;
    else rif.req_data[8*idx +: 8] = 8'($urandom);
    bit_err = 0; busy_err = 0; rdy_err = 0; mid = '0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        rst_b = 1'b0;
        #1;
        check("rst_sout", sout, 1);
        check("rst_busy", busy, 0);
        check("rst_rdy", rif.req_rdy, 0);
        check("rst_grant_id", grant_id, NREQ - 1);
        ptr_m = NREQ - 1;
        return;
      end
      if (sout !== frame_bit(exp_d, c / BITP)) bit_err++;
      if (busy !== 1'b1) busy_err++;
      if (rif.req_rdy !== '0) rdy_err++;
      if (c % BITP == BITP / 2) mid[c / BITP] = sout;
      if (c % BITP == BITP - 1) begin
        check($sformatf("frame_bit%0d", c / BITP), bit_err, 0);
        bit_err = 0;
      end
      if (c == raise_at) begin
        for (int i = 0; i < NREQ; i++)
          if (raise_mask[i] && !rif.req_vld[i]) set_req(i, 8'($urandom));
      end
    end
    check("busy_in_frame", busy_err, 0);
    check("rdy_in_frame", rdy_err, 0);
    check("decoded_byte", mid[8:1], exp_d);
    @(posedge clk);
    #1;
    check("busy_after", busy, 0);
    check("sout_after", sout, 1);
  endtask

  initial begin
    int idx, g, gprev, bad_s, bad_b, bad_r;
    logic [3:0] m;
    rif.req_vld  = '0;
    rif.req_data = '0;
    ptr_m = NREQ - 1;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_sout", sout, 1);
    check("reset_busy", busy, 0);
    check("reset_rdy", rif.req_rdy, 0);
    check("reset_grant_id", grant_id, 3);
    rst_b = 1'b1;

    // Idle line for 1000 cycles
    bad_s = 0; bad_b = 0; bad_r = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (sout !== 1'b1) bad_s++;
      if (busy !== 1'b0) bad_b++;
      if (rif.req_rdy !== '0) bad_r++;
    end
    check("idle_sout", bad_s, 0);
    check("idle_busy", bad_b, 0);
    check("idle_rdy", bad_r, 0);
    check("idle_grant_id", grant_id, 3);

    // Single byte 'A' from requester 2
    set_req(2, 8'h41);
    serve(1'b1, -1, '0, -1, idx, g);
    check("single_idx", idx, 2);

    // All four held: grants 0,1,2,3,0 one frame+1 apart
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'h30 + 8'(i));
    gprev = 0;
    for (int n = 0; n < 5; n++) begin
      serve(1'b0, -1, '0, -1, idx, g);
      check("rr_order", idx, n % NREQ);
      if (n > 0) check("b2b_gap", g - gprev, FRAME + 1);
      gprev = g;
    end
    rif.req_vld = '0;

    // Request arriving mid-frame waits, then pointer skips idle requesters
    set_req(3, 8'($urandom));
    serve(1'b1, -1, 4'b0010, 100, idx, gprev);
    serve(1'b1, -1, '0, -1, idx, g);
    check("midframe_idx", idx, 1);
    check("midframe_gap", g - gprev, FRAME + 1);

    // Parity-relevant byte 8'h43
    set_req(0, 8'h43);
    serve(1'b1, -1, '0, -1, idx, g);

    // Random masks and bytes
    gprev = g;
    for (int n = 0; n < 8; n++) begin
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++)
        if (m[i] && !rif.req_vld[i]) set_req(i, 8'($urandom));
      serve(1'($urandom_range(0, 1)), -1, '0, -1, idx, g);
      if (n > 0) check("rand_gap", g - gprev, FRAME + 1);
      gprev = g;
    end
    rif.req_vld = '0;

    // Reset during DATA bit 3 with requesters 0 and 3 pending
    set_req(2, 8'($urandom));
    serve(1'b1, 140, 4'b1001, 50, idx, g);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    serve(1'b1, -1, '0, -1, idx, g);
    check("post_reset_first", idx, 0);
    serve(1'b1, -1, '0, -1, idx, g);
    check("post_reset_second", idx, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
